// File: rtl/hog_cell_pkg.sv
// Shared constants and types for the HOG cell-histogram banks.
// Used by the A-port accumulating writer and the B-port normalisation reader model.
package hog_cell_pkg;

    localparam int unsigned CELL_GRID          = 34;
    localparam int unsigned BANK_CELLS_PER_ROW = 17;
    localparam int unsigned NUM_BINS           = 18;
    localparam int unsigned BANK_DEPTH         = 5202;
    localparam int unsigned BANK_ADDR_W        = 13;
    localparam int unsigned NUM_BANKS          = 4;
    localparam int unsigned BANK_SEL_W         = 2;
    localparam int unsigned COORD_W            = 6;
    localparam int unsigned BIN_W              = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Target of one read-modify-write: which bank and which word in it
    typedef struct packed {
        logic [BANK_SEL_W-1:0]  bank;
        logic [BANK_ADDR_W-1:0] addr;
    } bank_ref_t;

endpackage

// File: rtl/write_aport_cell_bin_if.sv
// Contribution stream plus the four bank A ports of the cell-histogram writer.
// slave is the writer's view; master is the contribution source / bank side.
interface write_aport_cell_bin_if
    import hog_cell_pkg::*;
#(
    parameter int unsigned TOTAL_BIT_WIDTH = 35,
    parameter int unsigned WEIGHT_WIDTH    = 16
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic [COORD_W-1:0]      in_row;
    logic [COORD_W-1:0]      in_col;
    logic [BIN_W-1:0]        in_bin;
    logic [WEIGHT_WIDTH-1:0] in_weight;

    logic [NUM_BANKS-1:0]                      ena;
    logic [NUM_BANKS-1:0]                      wea;
    logic [NUM_BANKS-1:0][BANK_ADDR_W-1:0]     addra;
    logic [NUM_BANKS-1:0][TOTAL_BIT_WIDTH-1:0] dina;
    logic [NUM_BANKS-1:0][TOTAL_BIT_WIDTH-1:0] douta;

    modport slave (
        input  in_valid, in_row, in_col, in_bin, in_weight, douta,
        output in_ready, ena, wea, addra, dina
    );

    modport master (
        output in_valid, in_row, in_col, in_bin, in_weight, douta,
        input  in_ready, ena, wea, addra, dina
    );

endinterface

// File: rtl/cell_bin_addr_gen.sv
// Maps a (row, col, bin) contribution to its bank, word address and range error.
// Purely combinational so the same mapping can be reused by the reader's model.
module cell_bin_addr_gen
    import hog_cell_pkg::*;
(
    input  logic [COORD_W-1:0]     row,
    input  logic [COORD_W-1:0]     col,
    input  logic [BIN_W-1:0]       bin,
    output logic [BANK_SEL_W-1:0]  bank_c,
    output logic [BANK_ADDR_W-1:0] addr_c,
    output logic                   range_err_c
);

    logic [BANK_ADDR_W-1:0] cell_idx;

    // odd/odd -> 0, odd/even -> 1, even/odd -> 2, even/even -> 3
    assign bank_c = {~row[0], ~col[0]};

    assign cell_idx = BANK_ADDR_W'(row[COORD_W-1:1]) * BANK_ADDR_W'(BANK_CELLS_PER_ROW)
                    + BANK_ADDR_W'(col[COORD_W-1:1]);

    assign addr_c = cell_idx * BANK_ADDR_W'(NUM_BINS) + BANK_ADDR_W'(bin);

    assign range_err_c = (row >= COORD_W'(CELL_GRID))
                      || (col >= COORD_W'(CELL_GRID))
                      || (bin >= BIN_W'(NUM_BINS));

endmodule

// File: rtl/write_aport_cell_bin.sv
// A-port writer for the four cell-histogram banks: zero-fill, read-modify-write
// accumulation with saturation, then drain and signal bin_ready.
module write_aport_cell_bin
    import hog_cell_pkg::*;
#(
    parameter int unsigned TOTAL_BIT_WIDTH = 35,
    parameter int unsigned WEIGHT_WIDTH    = 16
) (
    input  logic                  aclk,
    input  logic                  arest,
    input  logic                  frame_start,
    input  logic                  frame_end,
    output logic                  bin_ready,
    output logic                  err,
    write_aport_cell_bin_if.slave bus
);

    localparam int unsigned SUM_W = TOTAL_BIT_WIDTH + 1;
    localparam logic [BANK_ADDR_W-1:0] CLR_END = BANK_ADDR_W'(BANK_DEPTH);

    state_e                 state, state_n;
    logic [BANK_ADDR_W-1:0] clr_addr, clr_addr_n;
    logic                   err_n, bin_ready_n;
    logic [NUM_BANKS-1:0]   busy, busy_n;

    logic [NUM_BANKS-1:0]                      ena_q, ena_n;
    logic [NUM_BANKS-1:0]                      wea_q, wea_n;
    logic [NUM_BANKS-1:0][BANK_ADDR_W-1:0]     addra_q, addra_n;
    logic [NUM_BANKS-1:0][TOTAL_BIT_WIDTH-1:0] dina_q, dina_n;

    logic                    v1, v2;
    bank_ref_t               p1, p2;
    logic [WEIGHT_WIDTH-1:0] w1, w2;

    logic [BANK_SEL_W-1:0]  in_bank;
    logic [BANK_ADDR_W-1:0] in_addr;
    logic                   in_range_err;
    logic                   accept;

    logic [SUM_W-1:0]           sum_wide;
    logic [TOTAL_BIT_WIDTH-1:0] sum_sat;

    cell_bin_addr_gen u_addr_gen (
        .row         (bus.in_row),
        .col         (bus.in_col),
        .bin         (bus.in_bin),
        .bank_c      (in_bank),
        .addr_c      (in_addr),
        .range_err_c (in_range_err)
    );

    // busy spans the read and sum cycles; a same-bank op accepted during the
    // write cycle reads one cycle later and sees the committed word
    assign bus.in_ready = (state == ST_ACCUM) && !busy[in_bank];
    assign accept       = bus.in_valid && bus.in_ready;

    assign sum_wide = SUM_W'(bus.douta[p2.bank]) + SUM_W'(w2);
    assign sum_sat  = sum_wide[SUM_W-1] ? '1 : sum_wide[TOTAL_BIT_WIDTH-1:0];

    always_comb begin
        state_n     = state;
        clr_addr_n  = clr_addr;
        err_n       = err;
        bin_ready_n = 1'b0;
        busy_n      = busy;
        ena_n       = '0;
        wea_n       = '0;
        addra_n     = addra_q;
        dina_n      = dina_q;

        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    err_n      = 1'b0;
                    state_n    = ST_CLEAR;
                    ena_n      = '1;
                    wea_n      = '1;
                    addra_n    = '0;
                    dina_n     = '0;
                    clr_addr_n = BANK_ADDR_W'(1);
                end
            end
            // clr_addr holds the next word to zero; the write for word 0 was issued on entry
            ST_CLEAR: begin
                if (clr_addr == CLR_END) begin
                    state_n = ST_ACCUM;
                end else begin
                    ena_n      = '1;
                    wea_n      = '1;
                    addra_n    = {NUM_BANKS{clr_addr}};
                    dina_n     = '0;
                    clr_addr_n = clr_addr + BANK_ADDR_W'(1);
                end
            end
            ST_ACCUM: begin
                if (frame_end) state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!v1 && !v2 && (busy == '0)) begin
                    bin_ready_n = 1'b1;
                    state_n     = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (v2) begin
            ena_n[p2.bank]   = 1'b1;
            wea_n[p2.bank]   = 1'b1;
            addra_n[p2.bank] = p2.addr;
            dina_n[p2.bank]  = sum_sat;
            busy_n[p2.bank]  = 1'b0;
        end

        if (accept) begin
            if (in_range_err) begin
                err_n = 1'b1;
            end else begin
                ena_n[in_bank]   = 1'b1;
                addra_n[in_bank] = in_addr;
                busy_n[in_bank]  = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (arest) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge aclk) begin
        if (arest) begin
            clr_addr  <= '0;
            err       <= 1'b0;
            bin_ready <= 1'b0;
            busy      <= '0;
            ena_q     <= '0;
            wea_q     <= '0;
            addra_q   <= '0;
            dina_q    <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            p1        <= '0;
            p2        <= '0;
            w1        <= '0;
            w2        <= '0;
        end else begin
            clr_addr  <= clr_addr_n;
            err       <= err_n;
            bin_ready <= bin_ready_n;
            busy      <= busy_n;
            ena_q     <= ena_n;
            wea_q     <= wea_n;
            addra_q   <= addra_n;
            dina_q    <= dina_n;
            v1        <= accept && !in_range_err;
            v2        <= v1;
            p1        <= '{bank: in_bank, addr: in_addr};
            p2        <= p1;
            w1        <= bus.in_weight;
            w2        <= w1;
        end
    end

    assign bus.ena   = ena_q;
    assign bus.wea   = wea_q;
    assign bus.addra = addra_q;
    assign bus.dina  = dina_q;

endmodule
